// File: rtl/tank_lever_ctrl.sv
// Joystick/fire input stage: debounces the raw vector, decodes it into twin-tread
// lever targets and runs one reversal-guarded FSM per lever.
module tank_lever_ctrl #(
    parameter int DEB_CYCLES     = 4,
    parameter int NEUTRAL_CYCLES = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [3:0] joy_i,
    input  logic       fire_i,
    output logic       w_fw_n,
    output logic       w_bk_n,
    output logic       x_fw_n,
    output logic       x_bk_n,
    output logic       fire_o
);

    typedef enum logic [1:0] {ST_NEU, ST_FWD, ST_BCK, ST_DEAD} lever_state_t;
    typedef enum logic [1:0] {TGT_N, TGT_F, TGT_B} target_t;

    localparam logic [15:0] DEB_LAST  = 16'(DEB_CYCLES - 1);
    localparam logic [15:0] DEAD_LOAD = 16'(NEUTRAL_CYCLES - 1);

    logic [4:0]  raw;
    logic [4:0]  cand_reg;
    logic [4:0]  acc_reg;
    logic [15:0] cnt_reg;
    logic        fire_reg;

    assign raw = {joy_i, fire_i};

    // cnt saturates at DEB_LAST; acc keeps reloading from cand while the input stays put
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cand_reg <= '0;
            cnt_reg  <= '0;
            acc_reg  <= '0;
            fire_reg <= 1'b0;
        end else begin
            if (raw != cand_reg) begin
                cand_reg <= raw;
                cnt_reg  <= '0;
            end else if (cnt_reg < DEB_LAST) begin
                cnt_reg <= cnt_reg + 16'd1;
            end else begin
                acc_reg <= cand_reg;
            end
            fire_reg <= acc_reg[0];
        end
    end

    assign fire_o = fire_reg;

    // Index 0 is the left (W) lever, index 1 the right (X) lever.
    target_t lever_tgt [2];

    always_comb begin
        lever_tgt[0] = TGT_N;
        lever_tgt[1] = TGT_N;
        case (acc_reg[4:1])
            4'b1000: begin lever_tgt[0] = TGT_F; lever_tgt[1] = TGT_F; end
            4'b1010: begin lever_tgt[0] = TGT_N; lever_tgt[1] = TGT_F; end
            4'b1001: begin lever_tgt[0] = TGT_F; lever_tgt[1] = TGT_N; end
            4'b0001: begin lever_tgt[0] = TGT_F; lever_tgt[1] = TGT_B; end
            4'b0101: begin lever_tgt[0] = TGT_B; lever_tgt[1] = TGT_N; end
            4'b0100: begin lever_tgt[0] = TGT_B; lever_tgt[1] = TGT_B; end
            4'b0110: begin lever_tgt[0] = TGT_N; lever_tgt[1] = TGT_B; end
            4'b0010: begin lever_tgt[0] = TGT_B; lever_tgt[1] = TGT_F; end
            default: begin lever_tgt[0] = TGT_N; lever_tgt[1] = TGT_N; end
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lever
        target_t      tgt;
        lever_state_t state_reg;
        lever_state_t state_next;
        logic [15:0]  dcnt_reg;
        logic [15:0]  dcnt_next;
        logic         fw_n_reg;
        logic         bk_n_reg;

        assign tgt = lever_tgt[gi];

        always_comb begin
            state_next = state_reg;
            dcnt_next  = dcnt_reg;
            case (state_reg)
                ST_NEU: begin
                    if (tgt == TGT_F)      state_next = ST_FWD;
                    else if (tgt == TGT_B) state_next = ST_BCK;
                end
                ST_FWD: begin
                    if (tgt == TGT_N) begin
                        state_next = ST_NEU;
                    end else if (tgt == TGT_B) begin
                        state_next = ST_DEAD;
                        dcnt_next  = DEAD_LOAD;
                    end
                end
                ST_BCK: begin
                    if (tgt == TGT_N) begin
                        state_next = ST_NEU;
                    end else if (tgt == TGT_F) begin
                        state_next = ST_DEAD;
                        dcnt_next  = DEAD_LOAD;
                    end
                end
                ST_DEAD: begin
                    // Target wobble here does not reload the dead-time count
                    if (dcnt_reg != 16'd0)  dcnt_next  = dcnt_reg - 16'd1;
                    else if (tgt == TGT_F)  state_next = ST_FWD;
                    else if (tgt == TGT_B)  state_next = ST_BCK;
                    else                    state_next = ST_NEU;
                end
                default: state_next = ST_NEU;
            endcase
        end

        // Outputs decode the state being entered so they change on the same edge
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                state_reg <= ST_NEU;
                dcnt_reg  <= '0;
                fw_n_reg  <= 1'b1;
                bk_n_reg  <= 1'b1;
            end else begin
                state_reg <= state_next;
                dcnt_reg  <= dcnt_next;
                fw_n_reg  <= (state_next != ST_FWD);
                bk_n_reg  <= (state_next != ST_BCK);
            end
        end
    end

    assign w_fw_n = g_lever[0].fw_n_reg;
    assign w_bk_n = g_lever[0].bk_n_reg;
    assign x_fw_n = g_lever[1].fw_n_reg;
    assign x_bk_n = g_lever[1].bk_n_reg;

endmodule

// File: tb/tb_tank_lever_ctrl.sv
// Directed bench for tank_lever_ctrl (DEB_CYCLES=4, NEUTRAL_CYCLES=3).
// Observed vector is {w_fw_n, w_bk_n, x_fw_n, x_bk_n, fire_o}.
module tb_tank_lever_ctrl;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [3:0] joy_i;
    logic       fire_i;
    logic       w_fw_n, w_bk_n, x_fw_n, x_bk_n, fire_o;
    logic [4:0] obs;

    int checks = 0;
    int errors = 0;

    tank_lever_ctrl #(.DEB_CYCLES(4), .NEUTRAL_CYCLES(3)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .joy_i   (joy_i),
        .fire_i  (fire_i),
        .w_fw_n  (w_fw_n),
        .w_bk_n  (w_bk_n),
        .x_fw_n  (x_fw_n),
        .x_bk_n  (x_bk_n),
        .fire_o  (fire_o)
    );

    always #5 clk_sys = ~clk_sys;

    assign obs = {w_fw_n, w_bk_n, x_fw_n, x_bk_n, fire_o};

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic check(input string tag, input logic [4:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %-14s obs=%b exp=%b ok", tag, obs, exp);
        end else begin
            errors++;
            $display("FAIL %s obs=%b exp=%b", tag, obs, exp);
            $error("%s: obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        joy_i  = 4'b0000;
        fire_i = 1'b0;
        tick(2);
        reset = 1'b0;
        check("reset", 5'b11110);
        tick(20);
        check("idle20", 5'b11110);

        // Up + fire: accepted at edge 4, visible after edge 5
        joy_i = 4'b1000; fire_i = 1'b1;
        tick(5);  check("up_fire_e4", 5'b11110);
        tick(1);  check("up_fire_e5", 5'b01011);

        // Reversal Up -> Down: three neutral cycles then back
        joy_i = 4'b0100; fire_i = 1'b0;
        tick(5);  check("rev_e4", 5'b01011);
        tick(1);  check("rev_dead1", 5'b11110);
        tick(1);  check("rev_dead2", 5'b11110);
        tick(1);  check("rev_dead3", 5'b11110);
        tick(1);  check("rev_back", 5'b10100);

        // Reset out of BCK, then Up without fire
        reset = 1'b1;
        tick(1);  check("rst_from_bck", 5'b11110);
        reset = 1'b0; joy_i = 4'b1000;
        tick(6);  check("up", 5'b01010);

        // Illegal code goes straight to neutral
        joy_i = 4'b1100;
        tick(5);  check("illegal_e4", 5'b01010);
        tick(1);  check("illegal_e5", 5'b11110);

        // From neutral a Down command has no dead time
        joy_i = 4'b0100;
        tick(5);  check("nodead_e4", 5'b11110);
        tick(1);  check("nodead_back", 5'b10100);

        joy_i = 4'b0000;
        tick(6);  check("neutral", 5'b11110);

        // Left then Right: both levers reverse in lock-step
        joy_i = 4'b0010;
        tick(6);  check("left", 5'b10010);
        joy_i = 4'b0001;
        tick(5);  check("right_e4", 5'b10010);
        tick(1);  check("lr_dead1", 5'b11110);
        tick(2);  check("lr_dead3", 5'b11110);
        tick(1);  check("right", 5'b01100);

        // Up: W already forward and unaffected, only X goes through dead time
        joy_i = 4'b1000;
        tick(6);  check("indep_dead1", 5'b01110);
        tick(2);  check("indep_dead3", 5'b01110);
        tick(1);  check("indep_up", 5'b01010);

        // Glitch rejection from a clean reset
        reset = 1'b1; joy_i = 4'b0000;
        tick(1);
        reset = 1'b0;
        check("rst_glitch", 5'b11110);
        joy_i = 4'b1000;
        tick(3);
        joy_i = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick(1); check("glitch3", 5'b11110);
        end
        // Held for four samples only: one short of acceptance
        joy_i = 4'b1000;
        tick(4);
        joy_i = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick(1); check("glitch4", 5'b11110);
        end
        for (int i = 0; i < 20; i++) begin
            joy_i = (i % 2 == 0) ? 4'b1000 : 4'b0000;
            tick(2); check("alternate", 5'b11110);
        end

        // Reset during the second dead cycle aborts the reversal
        joy_i = 4'b1000;
        tick(6);  check("pre_dead_up", 5'b01010);
        joy_i = 4'b0100;
        tick(7);  check("dead_2nd", 5'b11110);
        reset = 1'b1;
        tick(1);  check("rst_in_dead", 5'b11110);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1); check("post_rst_wait", 5'b11110);
        end
        tick(1);  check("post_rst_back", 5'b10100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
